// File: rtl/ps2_keys_pkg.sv
// Scan-code and key-index constants shared by the PS/2 keypad receiver.
// Also holds the (ext, byte) -> key-index lookup used by the decoder.
// Pure definitions, no logic state.
package ps2_keys_pkg;

   // Prefix bytes
   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   // Player L, plain set-2 codes
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_S     = 8'h1B;

   // Player R, codes that must follow an E0 prefix
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   // Bit positions in the keys vector
   localparam logic [2:0] KEY_L_ROT   = 3'd0;
   localparam logic [2:0] KEY_L_LEFT  = 3'd1;
   localparam logic [2:0] KEY_L_RIGHT = 3'd2;
   localparam logic [2:0] KEY_L_DOWN  = 3'd3;
   localparam logic [2:0] KEY_R_ROT   = 3'd4;
   localparam logic [2:0] KEY_R_LEFT  = 3'd5;
   localparam logic [2:0] KEY_R_RIGHT = 3'd6;
   localparam logic [2:0] KEY_R_DOWN  = 3'd7;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } key_hit_t;

   // The extended flag selects the table, so keypad codes sent without E0
   // can never alias onto the arrow keys.
   function automatic key_hit_t key_lookup(input logic i_ext, input logic [7:0] i_code);
      key_hit_t res;
      res.hit = 1'b1;
      res.idx = KEY_L_ROT;
      if (!i_ext) begin
         case (i_code)
            SC_W:    res.idx = KEY_L_ROT;
            SC_A:    res.idx = KEY_L_LEFT;
            SC_D:    res.idx = KEY_L_RIGHT;
            SC_S:    res.idx = KEY_L_DOWN;
            default: res.hit = 1'b0;
         endcase
      end else begin
         case (i_code)
            SC_UP:    res.idx = KEY_R_ROT;
            SC_LEFT:  res.idx = KEY_R_LEFT;
            SC_RIGHT: res.idx = KEY_R_RIGHT;
            SC_DOWN:  res.idx = KEY_R_DOWN;
            default:  res.hit = 1'b0;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: synchronise, detect falling edges, assemble and check 11-bit frames.
// Latency: byte valid one clk after the stop bit is sampled (3 clks after the pin edge).
// Backpressure: none; o_vld is a single-cycle pulse that the consumer must take.
module ps2_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_vld
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic            r_clk_meta, r_clk_sync, r_clk_prev;
   logic            r_dat_meta, r_dat_sync;
   logic [3:0]      r_cnt;
   logic [9:0]      r_shift;
   logic [TO_W-1:0] r_to_cnt;

   logic w_fall;
   logic w_frame_ok;
   logic w_timeout;

   assign w_fall     = r_clk_prev & ~r_clk_sync;
   // r_shift[0]=start, [8:1]=data, [9]=parity; r_dat_sync is the stop bit now
   assign w_frame_ok = ~r_shift[0] & r_dat_sync & (^r_shift[9:1]);
   assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Two-flop synchronisers plus the previous-clock flop, idle-high after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= i_ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= i_ps2_data;
         r_dat_sync <= r_dat_meta;
      end
   end

   // Bit assembly, frame check on the 11th edge, and idle timeout for partial frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 4'd0;
         r_shift  <= 10'd0;
         r_to_cnt <= '0;
         o_byte   <= 8'd0;
         o_vld    <= 1'b0;
      end else begin
         o_vld <= 1'b0;
         if (w_fall) begin
            r_to_cnt <= '0;
            if (r_cnt == 4'd10) begin
               r_cnt <= 4'd0;
               if (w_frame_ok) begin
                  o_byte <= r_shift[8:1];
                  o_vld  <= 1'b1;
               end
            end else begin
               r_shift <= {r_dat_sync, r_shift[9:1]};
               r_cnt   <= r_cnt + 4'd1;
            end
         end else if (r_cnt != 4'd0) begin
            if (w_timeout) begin
               r_cnt    <= 4'd0;
               r_to_cnt <= '0;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_dual_keypad.sv
// Two-player PS/2 keypad: receives scan codes and holds eight key states (L: W/A/D/S, R: arrows).
// Latency: keys/code update one clk after the receiver's byte pulse (4 clks from the 11th pin edge).
// Backpressure: none; code_valid is a one-cycle pulse, keys are level-held.
module ps2_dual_keypad
   import ps2_keys_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keys,
   output logic [7:0] code,
   output logic       code_valid
);

   logic [7:0] w_byte;
   logic       w_vld;
   key_hit_t   w_hit;

   logic [7:0] r_keys;
   logic [7:0] r_code;
   logic       r_code_vld;
   logic       r_ext;
   logic       r_brk;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_data (ps2_data),
      .o_byte     (w_byte),
      .o_vld      (w_vld)
   );

   assign w_hit = key_lookup(r_ext, w_byte);

   // Prefix tracking and key-map update; a non-prefix byte always consumes both prefixes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_keys     <= 8'd0;
         r_code     <= 8'd0;
         r_code_vld <= 1'b0;
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
      end else begin
         r_code_vld <= 1'b0;
         if (w_vld) begin
            r_code     <= w_byte;
            r_code_vld <= 1'b1;
            if (w_byte == PREFIX_EXT) begin
               r_ext <= 1'b1;
            end else if (w_byte == PREFIX_BRK) begin
               r_brk <= 1'b1;
            end else begin
               if (w_hit.hit) begin
                  r_keys[w_hit.idx] <= ~r_brk;
               end
               r_ext <= 1'b0;
               r_brk <= 1'b0;
            end
         end
      end
   end

   assign keys       = r_keys;
   assign code       = r_code;
   assign code_valid = r_code_vld;

endmodule

// File: tb/tb_ps2_dual_keypad.sv
// Directed bench for ps2_dual_keypad: drives PS/2 frames on the pins and checks keys/code/code_valid.
// Latency of keys is checked exactly 4 clks after the stop-bit falling edge.
// Timeout is shortened so the idle test stays quick.
module tb_ps2_dual_keypad;

   localparam int unsigned TO = 1000;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keys;
   logic [7:0] code;
   logic       code_valid;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         vld_cnt = 0;
   logic [7:0] lat_keys;

   ps2_dual_keypad #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .keys       (keys),
      .code       (code),
      .code_valid (code_valid)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   always @(negedge clk) if (code_valid === 1'b1) vld_cnt++;

   // Drives nbits bits of a frame; after the 11th falling edge it snapshots keys 4 clks later.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = f[i];
         repeat (4) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            repeat (4) @(posedge clk);
            #1 lat_keys = keys;
         end
         repeat (4) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (keys !== 8'h00) begin $display("FAIL reset_keys: got %h want 00", keys); n_fail++; end
      n_tests++;
      if (code !== 8'h00) begin $display("FAIL reset_code: got %h want 00", code); n_fail++; end
      n_tests++;
      if (code_valid !== 1'b0) begin $display("FAIL reset_vld: got %b want 0", code_valid); n_fail++; end
   endtask

   task automatic test_single_make();
      int v0;
      v0 = vld_cnt;
      send_byte(8'h1C);
      n_tests++;
      if (lat_keys !== 8'h02) begin $display("FAIL make_latency: keys %h after 4 clks want 02", lat_keys); n_fail++; end
      n_tests++;
      if (code !== 8'h1C) begin $display("FAIL make_code: got %h want 1c", code); n_fail++; end
      n_tests++;
      if (vld_cnt - v0 !== 1) begin $display("FAIL make_pulses: got %0d want 1", vld_cnt - v0); n_fail++; end
   endtask

   task automatic test_break();
      send_byte(8'hF0);
      n_tests++;
      if (keys !== 8'h02 || code !== 8'hF0) begin
         $display("FAIL brk_prefix: keys %h code %h want 02 f0", keys, code); n_fail++;
      end
      send_byte(8'h1C);
      n_tests++;
      if (keys !== 8'h00) begin $display("FAIL brk_release: got %h want 00", keys); n_fail++; end
   endtask

   task automatic test_extended();
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'h6B);
      send_byte(8'h1D);
      n_tests++;
      if (keys !== 8'h31) begin $display("FAIL ext_hold: got %h want 31", keys); n_fail++; end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      n_tests++;
      if (keys !== 8'h21) begin $display("FAIL ext_release: got %h want 21", keys); n_fail++; end
   endtask

   task automatic test_unmapped();
      send_byte(8'h75);
      n_tests++;
      if (keys !== 8'h21) begin $display("FAIL plain_75: got %h want 21", keys); n_fail++; end
      send_byte(8'h1D);
      n_tests++;
      if (keys !== 8'h21) begin $display("FAIL typematic: got %h want 21", keys); n_fail++; end
      send_byte(8'hF0); send_byte(8'h1B);
      n_tests++;
      if (keys !== 8'h21) begin $display("FAIL brk_not_held: got %h want 21", keys); n_fail++; end
      send_byte(8'h12);
      n_tests++;
      if (keys !== 8'h21 || code !== 8'h12) begin
         $display("FAIL unmapped: keys %h code %h want 21 12", keys, code); n_fail++;
      end
   endtask

   task automatic test_bad_parity();
      int v0;
      send_byte(8'hF0); send_byte(8'h1D);
      n_tests++;
      if (keys !== 8'h20) begin $display("FAIL par_setup: got %h want 20", keys); n_fail++; end
      v0 = vld_cnt;
      send_frame(8'h1D, 1'b1, 11);
      n_tests++;
      if (keys !== 8'h20 || code !== 8'h1D) begin
         $display("FAIL par_drop: keys %h code %h want 20 1d", keys, code); n_fail++;
      end
      n_tests++;
      if (vld_cnt !== v0) begin $display("FAIL par_pulse: got %0d pulses want 0", vld_cnt - v0); n_fail++; end
   endtask

   task automatic test_timeout();
      send_frame(8'h1D, 1'b0, 5);
      repeat (TO + 10) @(negedge clk);
      send_byte(8'h23);
      n_tests++;
      if (keys !== 8'h24 || code !== 8'h23) begin
         $display("FAIL timeout: keys %h code %h want 24 23", keys, code); n_fail++;
      end
   endtask

   task automatic test_reset_midframe();
      send_byte(8'h1D); send_byte(8'h1C); send_byte(8'h23); send_byte(8'h1B);
      send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'h6B);
      send_byte(8'hE0); send_byte(8'h74); send_byte(8'hE0); send_byte(8'h72);
      n_tests++;
      if (keys !== 8'hFF) begin $display("FAIL all_held: got %h want ff", keys); n_fail++; end
      send_frame(8'h1D, 1'b0, 3);
      @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      n_tests++;
      if (keys !== 8'h00 || code !== 8'h00) begin
         $display("FAIL async_reset: keys %h code %h want 00 00", keys, code); n_fail++;
      end
      #10 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_byte(8'hE0); send_byte(8'h72);
      n_tests++;
      if (keys !== 8'h80) begin $display("FAIL post_reset: got %h want 80", keys); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_single_make();
      test_break();
      test_extended();
      test_unmapped();
      test_bad_parity();
      test_timeout();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
